// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
package dcache_pkg;

  // Default geometry: 8-bit byte address, 8 blocks of 4 bytes each.
  localparam int ADDR_BITS   = 8;
  localparam int INDEX_BITS  = 3;
  localparam int OFFSET_BITS = 2;
  localparam int TAG_BITS    = ADDR_BITS - INDEX_BITS - OFFSET_BITS;

  // Bit positions of the address fields: tag | index | offset.
  localparam int OFFSET_LSB  = 0;
  localparam int INDEX_LSB   = OFFSET_BITS;
  localparam int TAG_LSB     = OFFSET_BITS + INDEX_BITS;

  // Miss-sequencing states.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    FETCH      = 2'd2,
    UPDATE     = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_array.sv
// Cache storage: per-block valid/dirty/tag/data, with a byte-write port for
// cpu store hits, a block-write port for miss fills, and the hit comparator.
module dcache_array #(
  parameter int INDEX_BITS  = dcache_pkg::INDEX_BITS,
  parameter int OFFSET_BITS = dcache_pkg::OFFSET_BITS,
  parameter int TAG_BITS    = dcache_pkg::TAG_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [INDEX_BITS-1:0]         index,
  input  logic [TAG_BITS-1:0]           tag,
  input  logic [OFFSET_BITS-1:0]        offset,
  input  logic                          byte_we,
  input  logic [7:0]                    byte_data,
  input  logic                          block_we,
  input  logic [(8<<OFFSET_BITS)-1:0]   block_data,
  output logic                          hit,
  output logic                          cur_valid,
  output logic                          cur_dirty,
  output logic [TAG_BITS-1:0]           cur_tag,
  output logic [(8<<OFFSET_BITS)-1:0]   cur_data,
  output logic [7:0]                    cur_byte
);

  localparam int BLOCKS     = 1 << INDEX_BITS;
  localparam int BLOCK_BITS = 8 << OFFSET_BITS;

  logic [BLOCKS-1:0]     valid;
  logic [BLOCKS-1:0]     dirty;
  logic [TAG_BITS-1:0]   tag_mem  [BLOCKS];
  logic [BLOCK_BITS-1:0] data_mem [BLOCKS];

  // Status bits: cleared by reset, fills make a block valid and clean, stores dirty it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else if (block_we) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (byte_we) begin
      dirty[index] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; they are qualified by the valid bit.
  always_ff @(posedge clk) begin
    if (block_we) begin
      tag_mem[index]  <= tag;
      data_mem[index] <= block_data;
    end else if (byte_we) begin
      data_mem[index][{offset, 3'b000} +: 8] <= byte_data;
    end
  end

  // Read side and hit comparison for the currently selected block.
  always_comb begin
    cur_valid = valid[index];
    cur_dirty = dirty[index];
    cur_tag   = tag_mem[index];
    cur_data  = data_mem[index];
    cur_byte  = cur_data[{offset, 3'b000} +: 8];
    hit       = cur_valid & (cur_tag == tag);
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache between the cpu data port and a
// block-wide memory. Hits complete without stalling; a miss writes back the
// victim if dirty, fetches the new block, then installs it.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS  = dcache_pkg::INDEX_BITS,
  parameter int OFFSET_BITS = dcache_pkg::OFFSET_BITS,
  parameter int ADDR_BITS   = dcache_pkg::ADDR_BITS
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic                                READ,
  input  logic                                WRITE,
  input  logic [ADDR_BITS-1:0]                ADDRESS,
  input  logic [7:0]                          WRITEDATA,
  output logic [7:0]                          READDATA,
  output logic                                BUSYWAIT,
  output logic                                MEM_READ,
  output logic                                MEM_WRITE,
  output logic [ADDR_BITS-OFFSET_BITS-1:0]    MEM_ADDRESS,
  output logic [(8<<OFFSET_BITS)-1:0]         MEM_WRITEDATA,
  input  logic [(8<<OFFSET_BITS)-1:0]         MEM_READDATA,
  input  logic                                MEM_BUSYWAIT
);

  localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
  localparam int BLOCK_BITS = 8 << OFFSET_BITS;
  localparam int IDX_LSB    = OFFSET_BITS;
  localparam int TG_LSB     = OFFSET_BITS + INDEX_BITS;

  state_t                  state;
  logic                    seen;
  logic [TAG_BITS-1:0]     req_tag;
  logic [INDEX_BITS-1:0]   req_index;
  logic [BLOCK_BITS-1:0]   fill_data;

  logic [TAG_BITS-1:0]     a_tag;
  logic [INDEX_BITS-1:0]   a_index;
  logic [OFFSET_BITS-1:0]  a_offset;
  logic                    idle;
  logic                    access;
  logic [TAG_BITS-1:0]     arr_tag;
  logic [INDEX_BITS-1:0]   arr_index;
  logic                    byte_we;
  logic                    block_we;
  logic                    hit;
  logic                    cur_valid;
  logic                    cur_dirty;
  logic [TAG_BITS-1:0]     cur_tag;
  logic [BLOCK_BITS-1:0]   cur_data;
  logic [7:0]              cur_byte;

  // Address decode and array port steering: live address while idle, latched
  // request while a miss is in flight so a dropped request still completes.
  always_comb begin
    a_tag     = ADDRESS[TG_LSB +: TAG_BITS];
    a_index   = ADDRESS[IDX_LSB +: INDEX_BITS];
    a_offset  = ADDRESS[OFFSET_BITS-1:0];
    idle      = (state == IDLE);
    access    = READ | WRITE;
    arr_tag   = idle ? a_tag   : req_tag;
    arr_index = idle ? a_index : req_index;
    byte_we   = idle & WRITE & hit;
    block_we  = (state == UPDATE);
  end

  dcache_array #(
    .INDEX_BITS  (INDEX_BITS),
    .OFFSET_BITS (OFFSET_BITS),
    .TAG_BITS    (TAG_BITS)
  ) u_array (
    .clk        (CLK),
    .rst        (RESET),
    .index      (arr_index),
    .tag        (arr_tag),
    .offset     (a_offset),
    .byte_we    (byte_we),
    .byte_data  (WRITEDATA),
    .block_we   (block_we),
    .block_data (fill_data),
    .hit        (hit),
    .cur_valid  (cur_valid),
    .cur_dirty  (cur_dirty),
    .cur_tag    (cur_tag),
    .cur_data   (cur_data),
    .cur_byte   (cur_byte)
  );

  // Cpu-facing outputs: same-cycle hit data and stall; a simultaneous
  // read and write is a store, so no load data is returned for it.
  always_comb begin
    BUSYWAIT = 1'b0;
    READDATA = 8'h00;
    if (!RESET) begin
      BUSYWAIT = idle ? (access & ~hit) : 1'b1;
      if (idle && READ && !WRITE && hit)
        READDATA = cur_byte;
    end
  end

  // Miss sequencer; memory handshake outputs are registered and change on state entry.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      seen          <= 1'b0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      req_tag       <= '0;
      req_index     <= '0;
      fill_data     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access && !hit) begin
            req_tag   <= a_tag;
            req_index <= a_index;
            seen      <= 1'b0;
            if (cur_valid && cur_dirty) begin
              state         <= WRITE_BACK;
              MEM_WRITE     <= 1'b1;
              MEM_ADDRESS   <= {cur_tag, a_index};
              MEM_WRITEDATA <= cur_data;
            end else begin
              state       <= FETCH;
              MEM_READ    <= 1'b1;
              MEM_ADDRESS <= {a_tag, a_index};
            end
          end
        end
        // The first edge in a memory state only marks the request as seen, so a
        // memory that raises its busy flag one cycle late is not mistaken for done.
        WRITE_BACK: begin
          if (!seen) begin
            seen <= 1'b1;
          end else if (!MEM_BUSYWAIT) begin
            state       <= FETCH;
            seen        <= 1'b0;
            MEM_WRITE   <= 1'b0;
            MEM_READ    <= 1'b1;
            MEM_ADDRESS <= {req_tag, req_index};
          end
        end
        FETCH: begin
          if (!seen) begin
            seen <= 1'b1;
          end else if (!MEM_BUSYWAIT) begin
            state       <= UPDATE;
            seen        <= 1'b0;
            MEM_READ    <= 1'b0;
            MEM_ADDRESS <= '0;
            fill_data   <= MEM_READDATA;
          end
        end
        UPDATE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a fixed-latency block memory model.
module tb_dcache_controller;

  localparam int LAT = 5;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  ADDRESS = 8'h00;
  logic [7:0]  WRITEDATA = 8'h00;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  int vectors = 0;
  int miscompares = 0;

  dcache_controller dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Block memory: busy for LAT cycles after it sees a request, then one ready cycle.
  logic [31:0] mem [64];
  bit          mem_ready;
  int          cnt;

  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i) * 32'h0101_0101;
      mem[5]    <= 32'hDDCC_BBAA;
      mem[13]   <= 32'h4433_2211;
      mem_ready <= 1'b1;
      cnt       <= 0;
    end else if (MEM_READ || MEM_WRITE) begin
      if (cnt == LAT) begin
        cnt <= 0;
        if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
      end else begin
        cnt <= cnt + 1;
      end
    end else begin
      cnt <= 0;
    end
  end

  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (cnt != LAT);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Observations gathered while a miss is being serviced.
  bit          done;
  int          n_rd;
  int          n_wr;
  logic [5:0]  rd_addr;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  bit          rd_var;
  bit          order_bad;
  bit          both;

  task automatic wait_fill(input int budget);
    done = 0; n_rd = 0; n_wr = 0; rd_var = 0; order_bad = 0; both = 0;
    rd_addr = 6'h3F; wr_addr = 6'h3F; wr_data = 32'h0;
    for (int c = 0; c < budget; c++) begin
      @(negedge CLK);
      if (MEM_READ && MEM_WRITE) both = 1;
      if (MEM_WRITE) begin
        n_wr++;
        wr_addr = MEM_ADDRESS;
        wr_data = MEM_WRITEDATA;
        if (n_rd != 0) order_bad = 1;
      end
      if (MEM_READ) begin
        if (n_rd != 0 && MEM_ADDRESS != rd_addr) rd_var = 1;
        n_rd++;
        rd_addr = MEM_ADDRESS;
      end
      if (!BUSYWAIT) begin
        done = 1;
        break;
      end
    end
  endtask

  initial begin
    // Asynchronous reset asserted between clock edges
    #3 RESET = 1'b1;
    #1;
    chk("rst_busywait", 32'(BUSYWAIT), 32'h0);
    chk("rst_readdata", 32'(READDATA), 32'h0);
    chk("rst_mem_read", 32'(MEM_READ), 32'h0);
    chk("rst_mem_write", 32'(MEM_WRITE), 32'h0);
    chk("rst_mem_address", 32'(MEM_ADDRESS), 32'h0);
    chk("rst_mem_writedata", MEM_WRITEDATA, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    // Cold miss on 0x15: clean fetch of block 0x05
    @(negedge CLK);
    READ = 1'b1; ADDRESS = 8'h15;
    #1;
    chk("cold_busy_now", 32'(BUSYWAIT), 32'h1);
    wait_fill(60);
    chk("cold_done", 32'(done), 32'h1);
    chk("cold_readdata", 32'(READDATA), 32'hBB);
    chk("cold_fetch_cycles", 32'(n_rd), 32'(LAT + 1));
    chk("cold_fetch_addr", 32'(rd_addr), 32'h05);
    chk("cold_addr_stable", 32'(rd_var), 32'h0);
    chk("cold_no_writeback", 32'(n_wr), 32'h0);

    // Read hit on the same block
    ADDRESS = 8'h17;
    #1;
    chk("hit17_readdata", 32'(READDATA), 32'hDD);
    chk("hit17_busy", 32'(BUSYWAIT), 32'h0);
    chk("hit17_mem_idle", 32'({MEM_READ, MEM_WRITE}), 32'h0);
    @(negedge CLK);
    chk("hit17_busy_next", 32'(BUSYWAIT), 32'h0);
    chk("hit17_readdata_next", 32'(READDATA), 32'hDD);

    // Write hit: byte 2 of block 5 becomes 0x77
    READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h16; WRITEDATA = 8'h77;
    #1;
    chk("wr16_busy", 32'(BUSYWAIT), 32'h0);
    @(negedge CLK);
    WRITE = 1'b0; READ = 1'b1;
    #1;
    chk("wr16_mem_idle", 32'({MEM_READ, MEM_WRITE}), 32'h0);
    chk("rd16_after_write", 32'(READDATA), 32'h77);
    ADDRESS = 8'h14;
    #1;
    chk("rd14_untouched", 32'(READDATA), 32'hAA);

    // Conflict miss on 0x36: dirty victim written back, then block 0x0D fetched
    @(negedge CLK);
    ADDRESS = 8'h36;
    #1;
    chk("conf_busy_now", 32'(BUSYWAIT), 32'h1);
    wait_fill(80);
    chk("conf_done", 32'(done), 32'h1);
    chk("conf_wb_cycles", 32'(n_wr), 32'(LAT + 1));
    chk("conf_wb_addr", 32'(wr_addr), 32'h05);
    chk("conf_wb_data", wr_data, 32'hDD77_BBAA);
    chk("conf_fetch_cycles", 32'(n_rd), 32'(LAT + 1));
    chk("conf_fetch_addr", 32'(rd_addr), 32'h0D);
    chk("conf_wb_before_fetch", 32'(order_bad), 32'h0);
    chk("conf_never_both", 32'(both), 32'h0);
    chk("conf_readdata", 32'(READDATA), 32'h33);
    chk("conf_mem5_written", mem[5], 32'hDD77_BBAA);

    // Reset in the middle of a clean fetch of 0x15
    ADDRESS = 8'h15;
    @(negedge CLK);
    chk("mid_mem_read", 32'(MEM_READ), 32'h1);
    chk("mid_mem_address", 32'(MEM_ADDRESS), 32'h05);
    chk("mid_no_writeback", 32'(MEM_WRITE), 32'h0);
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("mid_rst_mem_read", 32'(MEM_READ), 32'h0);
    chk("mid_rst_mem_address", 32'(MEM_ADDRESS), 32'h0);
    chk("mid_rst_busywait", 32'(BUSYWAIT), 32'h0);
    chk("mid_rst_readdata", 32'(READDATA), 32'h0);
    READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("post_rst_quiet", 32'({MEM_READ, MEM_WRITE, BUSYWAIT}), 32'h0);
    READ = 1'b1; ADDRESS = 8'h15;
    #1;
    chk("refetch_busy_now", 32'(BUSYWAIT), 32'h1);
    wait_fill(60);
    chk("refetch_done", 32'(done), 32'h1);
    chk("refetch_cycles", 32'(n_rd), 32'(LAT + 1));
    chk("refetch_addr", 32'(rd_addr), 32'h05);
    chk("refetch_no_writeback", 32'(n_wr), 32'h0);
    chk("refetch_readdata", 32'(READDATA), 32'hBB);

    // READ and WRITE together behave as a store
    WRITE = 1'b1; ADDRESS = 8'h14; WRITEDATA = 8'h5A;
    #1;
    chk("rw_busy", 32'(BUSYWAIT), 32'h0);
    chk("rw_no_readdata", 32'(READDATA), 32'h0);
    @(negedge CLK);
    WRITE = 1'b0;
    #1;
    chk("rw_stored", 32'(READDATA), 32'h5A);
    ADDRESS = 8'h16;
    #1;
    chk("rw_neighbour", 32'(READDATA), 32'h77);
    READ = 1'b0;
    @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
